// File: rtl/dmux_stream_ctrl_pkg.sv
// dmux_stream_ctrl_pkg: FSM state encoding and width derivations shared by the stream controller.
package dmux_stream_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_e;

    function automatic int sel_w(input int oc);
        return $clog2(oc) + 1;
    endfunction

    function automatic int cnt_w(input int c);
        return $clog2(c + 1);
    endfunction

endpackage

// File: rtl/dmux_credit_counter.sv
// dmux_credit_counter: per-destination credit count that saturates at CREDITS and flags over-returns.
module dmux_credit_counter #(
    parameter int CREDITS = 2,
    parameter int CW      = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic take,
    input  logic ret,
    output logic nonzero,
    output logic overflow_pulse
);
    logic [CW-1:0] cnt_q, cnt_d;
    logic full;

    always_comb begin
        full           = cnt_q == CW'(CREDITS);
        overflow_pulse = ret && !take && full;
        nonzero        = cnt_q != '0;
        cnt_d          = (take && !ret) ? cnt_q - 1'b1 :
                         (ret && !take && !full) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= CW'(CREDITS);
        else        cnt_q <= cnt_d;

endmodule

// File: rtl/dmux_stream_ctrl.sv
// dmux_stream_ctrl: schedules a tagged valid/ready stream into the fixed-latency demux,
// holding sel stable while beats are in flight and applying per-destination credits.
module dmux_stream_ctrl
    import dmux_stream_ctrl_pkg::*;
#(
    parameter int WIDTH        = 1,
    parameter int OUTPUT_COUNT = 2,
    parameter int LATENCY      = 0,
    parameter int CREDITS      = 2,
    localparam int SEL_W       = sel_w(OUTPUT_COUNT),
    localparam int CW          = cnt_w(CREDITS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [SEL_W-1:0]        s_sel,
    input  logic [WIDTH-1:0]        s_data,
    output logic [SEL_W-1:0]        dmux_sel,
    output logic [WIDTH-1:0]        dmux_in,
    output logic [OUTPUT_COUNT-1:0] m_valid,
    input  logic [OUTPUT_COUNT-1:0] credit_ret,
    output logic                    busy,
    output logic                    err_oor,
    output logic                    err_credit
);
    state_e                  state_q, state_d;
    logic [LATENCY:0]        vld_pipe_q, vld_pipe_d;
    logic [SEL_W-1:0]        cur_sel_q, cur_sel_d;
    logic [WIDTH-1:0]        dmux_in_q;
    logic                    err_oor_q, err_credit_q;
    logic [OUTPUT_COUNT-1:0] credit_nz, take, ovf, sel_hot, cur_hot;
    logic                    in_range, credit_ok, same_sel, pipe_empty, acc, acc_in;

    always_comb begin
        sel_hot = '0;
        cur_hot = '0;
        for (int d = 0; d < OUTPUT_COUNT; d++) begin
            sel_hot[d] = s_sel == SEL_W'(d);
            cur_hot[d] = cur_sel_q == SEL_W'(d);
        end
        in_range   = s_sel < SEL_W'(OUTPUT_COUNT);
        credit_ok  = |(sel_hot & credit_nz);
        pipe_empty = vld_pipe_q == '0;
        same_sel   = s_sel == cur_sel_q;
        // Out-of-range beats are always swallowed; in-range ones wait for credit and a quiet pipe or same sel.
        s_ready    = rst_n && (!in_range ||
                     (credit_ok && (pipe_empty || (same_sel && state_q != DRAIN))));
        acc        = s_valid && s_ready;
        acc_in     = acc && in_range;
        take       = sel_hot & {OUTPUT_COUNT{acc_in}};
        vld_pipe_d = (LATENCY+1)'({vld_pipe_q, acc_in});
        cur_sel_d  = acc_in ? s_sel : cur_sel_q;
        state_d    = acc_in ? STREAM :
                     (state_q != IDLE && s_valid && in_range && !same_sel && !pipe_empty) ? DRAIN :
                     pipe_empty ? IDLE : state_q;
    end

    for (genvar i = 0; i < OUTPUT_COUNT; i++) begin : g_cnt
        dmux_credit_counter #(.CREDITS(CREDITS), .CW(CW)) u_cnt (
            .clk           (clk),
            .rst_n         (rst_n),
            .take          (take[i]),
            .ret           (credit_ret[i]),
            .nonzero       (credit_nz[i]),
            .overflow_pulse(ovf[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q      <= IDLE;
            vld_pipe_q   <= '0;
            cur_sel_q    <= '0;
            dmux_in_q    <= '0;
            err_oor_q    <= 1'b0;
            err_credit_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            vld_pipe_q   <= vld_pipe_d;
            cur_sel_q    <= cur_sel_d;
            dmux_in_q    <= acc_in ? s_data : '0;
            err_oor_q    <= acc && !in_range;
            err_credit_q <= err_credit_q || |ovf;
        end

    assign dmux_sel   = cur_sel_q;
    assign dmux_in    = dmux_in_q;
    assign m_valid    = cur_hot & {OUTPUT_COUNT{vld_pipe_q[LATENCY]}};
    assign busy       = !pipe_empty;
    assign err_oor    = err_oor_q;
    assign err_credit = err_credit_q;

endmodule

// File: tb/tb_dmux_stream_ctrl.sv
// tb_dmux_stream_ctrl: directed stimulus with a scoreboard queue; a monitor pops expected beats on m_valid.
module tb_dmux_stream_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       s_valid, s_ready;
    logic [2:0] s_sel, dmux_sel;
    logic [7:0] s_data, dmux_in;
    logic [3:0] m_valid, credit_ret;
    logic       busy, err_oor, err_credit;

    typedef struct {
        logic [3:0] mv;
        logic [7:0] d;
        int         at;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    int         cyc = 0;
    int         n_chk = 0;
    int         n_fail = 0;
    logic [7:0] d1 = '0, d2 = '0;

    dmux_stream_ctrl #(.WIDTH(8), .OUTPUT_COUNT(4), .LATENCY(2), .CREDITS(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_sel     (s_sel),
        .s_data    (s_data),
        .dmux_sel  (dmux_sel),
        .dmux_in   (dmux_in),
        .m_valid   (m_valid),
        .credit_ret(credit_ret),
        .busy      (busy),
        .err_oor   (err_oor),
        .err_credit(err_credit)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one beat this cycle, check s_ready and record the expected demux output if accepted.
    task automatic offer(input logic [2:0] sel, input logic [7:0] d, input logic exp_rdy,
                         input logic push, input string name);
        s_valid = 1'b1;
        s_sel   = sel;
        s_data  = d;
        #1;
        chk(name, 32'(s_ready), 32'(exp_rdy));
        if (exp_rdy && push && sel < 3'd4)
            sb.push_back('{4'(32'd1 << sel), d, cyc + 3});
    endtask

    always @(negedge clk) begin
        if (rst_n && m_valid != '0) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_m_valid: got %b expected none (cycle %0d)", m_valid, cyc);
            end else begin
                e = sb.pop_front();
                chk("m_valid", 32'(m_valid), 32'(e.mv));
                chk("m_valid_cycle", 32'(cyc), 32'(e.at));
                chk("beat_data", 32'(d2), 32'(e.d));
            end
        end
        d2 = d1;
        d1 = dmux_in;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        s_valid = 1'b0; s_sel = '0; s_data = '0; credit_ret = '0;
        repeat (3) @(negedge clk);
        s_valid = 1'b1;
        #1;
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_dmux_sel", 32'(dmux_sel), 32'd0);
        chk("rst_dmux_in", 32'(dmux_in), 32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err_oor", 32'(err_oor), 32'd0);
        chk("rst_err_credit", 32'(err_credit), 32'd0);
        s_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        offer(3'd1, 8'hA5, 1'b1, 1'b1, "single_rdy");
        @(negedge clk);
        s_valid = 1'b0;
        #1;
        chk("single_dmux_in", 32'(dmux_in), 32'hA5);
        chk("single_dmux_sel", 32'(dmux_sel), 32'd1);
        chk("single_busy1", 32'(busy), 32'd1);
        @(negedge clk); #1;
        chk("single_busy2", 32'(busy), 32'd1);
        chk("single_in_clear", 32'(dmux_in), 32'd0);
        @(negedge clk); #1;
        chk("single_busy3", 32'(busy), 32'd1);
        @(negedge clk); #1;
        chk("single_busy4", 32'(busy), 32'd0);
        credit_ret = 4'b0010;
        @(negedge clk);
        credit_ret = '0;
        repeat (2) @(negedge clk);
        offer(3'd2, 8'h11, 1'b1, 1'b1, "cr_first");
        @(negedge clk);
        offer(3'd2, 8'h22, 1'b1, 1'b1, "cr_second");
        @(negedge clk);
        offer(3'd2, 8'h33, 1'b0, 1'b1, "cr_block1");
        @(negedge clk);
        offer(3'd2, 8'h33, 1'b0, 1'b1, "cr_block2");
        credit_ret = 4'b0100;
        @(negedge clk);
        offer(3'd2, 8'h33, 1'b1, 1'b1, "cr_after_ret");
        @(negedge clk);
        credit_ret = '0;
        offer(3'd2, 8'h44, 1'b1, 1'b1, "cr_same_cycle_kept");
        @(negedge clk);
        offer(3'd2, 8'h55, 1'b0, 1'b1, "cr_exhausted");
        @(negedge clk);
        s_valid = 1'b0;
        credit_ret = 4'b0100;
        @(negedge clk);
        @(negedge clk);
        credit_ret = '0;
        repeat (4) @(negedge clk);
        chk("cr_idle", 32'(busy), 32'd0);
        offer(3'd0, 8'h5A, 1'b1, 1'b1, "sw_first");
        @(negedge clk);
        offer(3'd3, 8'hC3, 1'b0, 1'b1, "sw_block1");
        @(negedge clk);
        offer(3'd3, 8'hC3, 1'b0, 1'b1, "sw_block2");
        @(negedge clk);
        offer(3'd3, 8'hC3, 1'b0, 1'b1, "sw_block3");
        @(negedge clk);
        offer(3'd3, 8'hC3, 1'b1, 1'b1, "sw_accept");
        @(negedge clk);
        s_valid = 1'b0;
        repeat (5) @(negedge clk);
        credit_ret = 4'b1001;
        @(negedge clk);
        credit_ret = '0;
        @(negedge clk);
        offer(3'd5, 8'hFF, 1'b1, 1'b1, "oor_rdy");
        @(negedge clk);
        s_valid = 1'b0;
        #1;
        chk("oor_err", 32'(err_oor), 32'd1);
        chk("oor_busy", 32'(busy), 32'd0);
        chk("oor_dmux_in", 32'(dmux_in), 32'd0);
        chk("oor_cur_sel", 32'(dmux_sel), 32'd3);
        @(negedge clk); #1;
        chk("oor_err_pulse", 32'(err_oor), 32'd0);
        credit_ret = 4'b0001;
        #1;
        chk("ovf_before", 32'(err_credit), 32'd0);
        @(negedge clk);
        credit_ret = '0;
        #1;
        chk("ovf_set", 32'(err_credit), 32'd1);
        repeat (3) @(negedge clk);
        #1;
        chk("ovf_sticky", 32'(err_credit), 32'd1);
        offer(3'd0, 8'h01, 1'b1, 1'b1, "ovf_sat1");
        @(negedge clk);
        offer(3'd0, 8'h02, 1'b1, 1'b1, "ovf_sat2");
        @(negedge clk);
        offer(3'd0, 8'h03, 1'b0, 1'b1, "ovf_sat_block");
        @(negedge clk);
        s_valid = 1'b0;
        credit_ret = 4'b0001;
        @(negedge clk);
        @(negedge clk);
        credit_ret = '0;
        repeat (4) @(negedge clk);
        offer(3'd1, 8'h01, 1'b1, 1'b0, "rst_mid_rdy1");
        @(negedge clk);
        offer(3'd1, 8'h02, 1'b1, 1'b0, "rst_mid_rdy2");
        @(negedge clk);
        s_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_m_valid", 32'(m_valid), 32'd0);
        chk("rst_mid_dmux_in", 32'(dmux_in), 32'd0);
        chk("rst_mid_dmux_sel", 32'(dmux_sel), 32'd0);
        chk("rst_mid_err_credit", 32'(err_credit), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        offer(3'd1, 8'h66, 1'b1, 1'b1, "post_rst_rdy1");
        @(negedge clk);
        offer(3'd1, 8'h77, 1'b1, 1'b1, "post_rst_rdy2");
        @(negedge clk);
        s_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
